// File: rtl/spi_peripheral.sv
// SPI mode-0 target: oversamples the SPI pins in the clk domain, receives MSB-first
// into a one-byte valid/ready buffer, and shifts a queued transmit byte out on spi_miso.
module spi_peripheral #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  IDLE_BYTE   = 8'hff
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_clk,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       rx_overrun
);

  typedef enum logic [1:0] {RESYNC, IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync, r_cs_sync, r_mosi_sync;
  logic                   r_sck_q, r_cs_q;
  state_t                 r_state, w_state_nxt;
  logic [2:0]             r_bit_cnt, w_bit_cnt_nxt;
  logic [7:0]             r_rx_shift, w_rx_shift_nxt;
  logic [7:0]             r_tx_shift, w_tx_shift_nxt;
  logic [7:0]             r_tx_hold, w_tx_hold_nxt;
  logic                   r_tx_full, w_tx_full_nxt;
  logic [7:0]             r_rx_data, w_rx_data_nxt;
  logic                   r_rx_valid, w_rx_valid_nxt;
  logic                   r_overrun, w_overrun_nxt;
  logic                   r_miso, w_miso_nxt;
  logic                   r_miso_oe, w_miso_oe_nxt;
  logic                   w_reload;
  logic [7:0]             w_rx_byte;

  logic w_sck_s, w_cs_s, w_mosi_s;
  logic w_sck_rise, w_sck_fall, w_cs_fall, w_cs_rise;

  assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_s     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck_s & ~r_sck_q;
  assign w_sck_fall = ~w_sck_s & r_sck_q;
  assign w_cs_fall  = ~w_cs_s & r_cs_q;
  assign w_cs_rise  = w_cs_s & ~r_cs_q;

  // Synchronizers, edge-detect history and all registered state.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_q     <= 1'b0;
      r_cs_q      <= 1'b1;
      r_state     <= RESYNC;
      r_bit_cnt   <= 3'd0;
      r_rx_shift  <= 8'd0;
      r_tx_shift  <= IDLE_BYTE;
      r_tx_hold   <= 8'd0;
      r_tx_full   <= 1'b0;
      r_rx_data   <= 8'd0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
      r_miso      <= 1'b1;
      r_miso_oe   <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_clk};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_q     <= w_sck_s;
      r_cs_q      <= w_cs_s;
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_rx_shift  <= w_rx_shift_nxt;
      r_tx_shift  <= w_tx_shift_nxt;
      r_tx_hold   <= w_tx_hold_nxt;
      r_tx_full   <= w_tx_full_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_overrun   <= w_overrun_nxt;
      r_miso      <= w_miso_nxt;
      r_miso_oe   <= w_miso_oe_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_rx_shift_nxt = r_rx_shift;
    w_tx_shift_nxt = r_tx_shift;
    w_tx_hold_nxt  = r_tx_hold;
    w_tx_full_nxt  = r_tx_full;
    w_rx_data_nxt  = r_rx_data;
    w_rx_valid_nxt = r_rx_valid;
    w_overrun_nxt  = 1'b0;
    w_reload       = 1'b0;
    w_rx_byte      = {r_rx_shift[6:0], w_mosi_s};

    if (r_rx_valid && rx_ready) w_rx_valid_nxt = 1'b0;
    if (tx_valid && !r_tx_full) begin
      w_tx_hold_nxt = tx_data;
      w_tx_full_nxt = 1'b1;
    end

    case (r_state)
      RESYNC: if (w_cs_s) w_state_nxt = IDLE;
      IDLE: begin
        if (w_cs_fall) begin
          w_state_nxt   = SHIFT;
          w_bit_cnt_nxt = 3'd0;
          w_reload      = 1'b1;
        end
      end
      SHIFT: begin
        if (w_cs_rise) begin
          w_state_nxt = IDLE;
        end else if (w_sck_rise) begin
          w_rx_shift_nxt = w_rx_byte;
          w_bit_cnt_nxt  = r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (!r_rx_valid || rx_ready) begin
              w_rx_data_nxt  = w_rx_byte;
              w_rx_valid_nxt = 1'b1;
            end else begin
              w_overrun_nxt = 1'b1;
            end
          end
        end else if (w_sck_fall) begin
          if (r_bit_cnt == 3'd0) w_reload = 1'b1;
          else                   w_tx_shift_nxt = {r_tx_shift[6:0], 1'b1};
        end
      end
      default: w_state_nxt = RESYNC;
    endcase

    // Reload never sees a same-cycle push: a push needs an empty holder.
    if (w_reload) begin
      w_tx_shift_nxt = r_tx_full ? r_tx_hold : IDLE_BYTE;
      if (r_tx_full) w_tx_full_nxt = 1'b0;
    end

    w_miso_oe_nxt = (w_state_nxt == SHIFT);
    w_miso_nxt    = (w_state_nxt == SHIFT) ? w_tx_shift_nxt[7] : 1'b1;
  end

  assign spi_miso    = r_miso;
  assign spi_miso_oe = r_miso_oe;
  assign rx_data     = r_rx_data;
  assign rx_valid    = r_rx_valid;
  assign tx_ready    = ~r_tx_full;
  assign rx_overrun  = r_overrun;

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: a mode-0 master model with rx/miso scoreboards
// and a negedge monitor that pops expected receive bytes on each handshake.
module tb_spi_peripheral;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       spi_clk = 1'b0;
  logic       spi_cs_n = 1'b1;
  logic       spi_mosi = 1'b0;
  logic       spi_miso, spi_miso_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b1;
  logic [7:0] tx_data = 8'd0;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       rx_overrun;

  int total = 0;
  int bad = 0;
  int rv_cycles = 0;
  int ovr_cnt = 0;
  int pops = 0;
  logic [31:0] rxq[$];
  logic [31:0] txq[$];
  logic [7:0]  mi;

  spi_peripheral #(.SYNC_STAGES(2), .IDLE_BYTE(8'hff)) dut (
    .clk(clk), .reset(reset), .spi_clk(spi_clk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_miso_oe(spi_miso_oe),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_overrun(rx_overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Mode-0 master: n bits MSB-first, f_spi = clk/8; optional rx_ready pulse on last bit.
  task automatic send_bits(input logic [7:0] b, input int n, input bit rdy_pulse,
                           output logic [7:0] m);
    m = 8'd0;
    for (int i = 7; i > 7 - n; i--) begin
      spi_mosi = b[i];
      tick(4);
      m[i] = spi_miso;
      spi_clk = 1'b1;
      for (int j = 1; j <= 4; j++) begin
        tick();
        if (rdy_pulse && i == 0 && j == 2) rx_ready = 1'b1;
        if (rdy_pulse && i == 0 && j == 3) rx_ready = 1'b0;
      end
      spi_clk = 1'b0;
    end
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
  endtask

  task automatic cs_high();
    tick(4);
    spi_cs_n = 1'b1;
    tick(8);
  endtask

  // Handshake monitor, sampled mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid) rv_cycles++;
      if (rx_overrun) ovr_cnt++;
      if (rx_valid && rx_ready) begin
        pops++;
        chk("rx_data", {24'd0, rx_data}, (rxq.size() > 0) ? rxq.pop_front() : 32'hdead_beef);
      end
    end
  end

  initial begin
    tick(3);
    chk("rst_miso", {31'd0, spi_miso}, 32'd1);
    chk("rst_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    chk("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_overrun", {31'd0, rx_overrun}, 32'd0);
    reset = 1'b0;
    tick(6);

    // 1: single byte with rx_ready high
    rv_cycles = 0; ovr_cnt = 0; pops = 0;
    rxq.push_back(32'h0000_00a5);
    cs_low();
    send_bits(8'ha5, 8, 1'b0, mi);
    chk("t1_oe_in_frame", {31'd0, spi_miso_oe}, 32'd1);
    chk("t1_idle_miso", {24'd0, mi}, 32'h0000_00ff);
    cs_high();
    chk("t1_oe_after", {31'd0, spi_miso_oe}, 32'd0);
    chk("t1_rv_cycles", 32'(rv_cycles), 32'd1);
    chk("t1_pops", 32'(pops), 32'd1);
    chk("t1_overrun", 32'(ovr_cnt), 32'd0);

    // 2: queued tx byte, then idle byte
    tx_data = 8'h3c; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    tick();
    chk("t2_tx_ready_full", {31'd0, tx_ready}, 32'd0);
    rxq.push_back(32'h0000_00f0);
    rxq.push_back(32'h0000_000f);
    txq.push_back(32'h0000_003c);
    txq.push_back(32'h0000_00ff);
    cs_low();
    tick(4);
    chk("t2_tx_ready_after_csfall", {31'd0, tx_ready}, 32'd1);
    send_bits(8'hf0, 8, 1'b0, mi);
    chk("t2_miso_b0", {24'd0, mi}, txq.pop_front());
    send_bits(8'h0f, 8, 1'b0, mi);
    chk("t2_miso_b1", {24'd0, mi}, txq.pop_front());
    cs_high();

    // 3: overrun with rx_ready low
    rx_ready = 1'b0; ovr_cnt = 0;
    rxq.push_back(32'h0000_0011);
    cs_low();
    send_bits(8'h11, 8, 1'b0, mi);
    send_bits(8'h22, 8, 1'b0, mi);
    cs_high();
    chk("t3_rx_data_held", {24'd0, rx_data}, 32'h0000_0011);
    chk("t3_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("t3_overrun", 32'(ovr_cnt), 32'd1);
    rx_ready = 1'b1;
    tick(2);
    chk("t3_drained", {31'd0, rx_valid}, 32'd0);

    // 4: consume in the exact cycle the second byte completes
    rx_ready = 1'b0; ovr_cnt = 0;
    rxq.push_back(32'h0000_0011);
    rxq.push_back(32'h0000_0022);
    cs_low();
    send_bits(8'h11, 8, 1'b0, mi);
    send_bits(8'h22, 8, 1'b1, mi);
    cs_high();
    chk("t4_rx_data", {24'd0, rx_data}, 32'h0000_0022);
    chk("t4_rx_valid", {31'd0, rx_valid}, 32'd1);
    chk("t4_overrun", 32'(ovr_cnt), 32'd0);
    rx_ready = 1'b1;
    tick(2);

    // 5: partial byte discarded, then full frame
    pops = 0;
    rxq.push_back(32'h0000_00c3);
    cs_low();
    send_bits(8'hff, 5, 1'b0, mi);
    cs_high();
    chk("t5_no_partial", 32'(pops), 32'd0);
    cs_low();
    send_bits(8'hc3, 8, 1'b0, mi);
    cs_high();
    chk("t5_pops", 32'(pops), 32'd1);

    // 6: reset mid-byte with cs low
    pops = 0; rv_cycles = 0;
    cs_low();
    send_bits(8'hff, 3, 1'b0, mi);
    tx_data = 8'h77; tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("t6_tx_ready", {31'd0, tx_ready}, 32'd1);
    chk("t6_oe", {31'd0, spi_miso_oe}, 32'd0);
    chk("t6_miso", {31'd0, spi_miso}, 32'd1);
    send_bits(8'hff, 5, 1'b0, mi);
    cs_high();
    chk("t6_no_rx", 32'(rv_cycles), 32'd0);
    rxq.push_back(32'h0000_005a);
    cs_low();
    send_bits(8'h5a, 8, 1'b0, mi);
    chk("t6_miso_idle", {24'd0, mi}, 32'h0000_00ff);
    cs_high();
    chk("t6_pops", 32'(pops), 32'd1);

    chk("rxq_empty", 32'(rxq.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
